psum_drain_ctrl: RTL and testbench
==================================

// Module: psum_drain_ctrl
// PURPOSE
//  Drains the partial sums of the ROWSxCOLS output-stationary PE array into the output buffer once a computation ends.
//  On drainStart it snapshots every PE psum into a shadow bank and pulses the per-PE psum clear, so the array controller
//  can restart at once. It then streams the snapshot out one word per valid/ready handshake, in row-major order.
//  Sits between the array controller (its start source), the PE array (psum taps, clear) and the output SRAM writer.
// PARAMETERS
//  ROWS    4   PE array rows
//  COLS    4   PE array columns
//  PSUM_W  16  signed psum width per PE
//  ADDR_W  8   output buffer address width
// PORTS
//  clk            in   1              system clock, all state on rising edge
//  rstnSys        in   1              asynchronous active-low reset
//  drainStart     in   1              1-cycle pulse: array results final, begin drain
//  baseAddr       in   ADDR_W         output base address, sampled with drainStart
//  psumIn         in   ROWS*COLS*PSUM_W  flattened PE psums, PE k = bits [k*PSUM_W +: PSUM_W], k = r*COLS+c
//  rstnPsumDrain  out  ROWS*COLS      active-low per-PE psum clear, ANDed with the controller's own clear
//  outValid       out  1              outData/outAddr valid
//  outReady       in   1              sink accepts the word this cycle
//  outData        out  PSUM_W         drained psum
//  outAddr        out  ADDR_W         write address for outData
//  busy           out  1              high from drainStart capture until done
//  done           out  1              1-cycle pulse after the last word is accepted
//  overrun        out  1              sticky: drainStart arrived while not IDLE
// BEHAVIOUR
//  Reset (async, rstnSys=0): state IDLE, idx=0; shadow bank cleared; rstnPsumDrain all 1.
//    outValid=0, outData=0, outAddr=0, busy=0, done=0, overrun=0. Reset mid-drain abandons the stream without a done pulse.
//  FSM: IDLE -> CLEAR -> SEND -> DONE -> IDLE.
//  IDLE: on drainStart at edge t: shadow <= psumIn, base <= baseAddr, idx <= 0; go to CLEAR.
//  CLEAR (cycle t+1): rstnPsumDrain = all 0 for exactly this cycle; busy=1; outValid=0; go to SEND.
//  SEND: outValid=1, outData=shadow[idx], outAddr=(base+idx) mod 2^ADDR_W, so addresses wrap and no error is raised.
//    On outValid&&outReady: idx++. If idx==ROWS*COLS-1, go to DONE.
//    While outValid=1 and outReady=0, outData and outAddr stay stable.
//  DONE: done=1 for one cycle, busy=0, outValid=0; next state IDLE. Back-to-back drains therefore have a gap of at least 1 cycle.
//  First word is visible at cycle t+2. With outReady held high, done pulses at t+2+ROWS*COLS and busy spans t+1..t+1+ROWS*COLS.
//  drainStart in any state other than IDLE (CLEAR, SEND or DONE) is ignored and sets overrun=1. Only reset clears overrun.
//  Outputs are registered. outData/outAddr are driven from registered state and idx through the read mux.
// CONFIGURATION
//  DRAIN_RELU_EN defined: outData = (shadow[idx] < 0 signed) ? 0 : shadow[idx]. This is combinational on the mux output and adds no latency.
//  DRAIN_RELU_EN undefined: outData = shadow[idx] unmodified (two's complement passthrough).
// STRUCTURE
//  Shared package/header systolic_pkg: ROWS, COLS, PSUM_W, ADDR_W defaults; drain state encoding
//    (IDLE=0, CLEAR=1, SEND=2, DONE=3); NUM_PE = ROWS*COLS.
//  Sub-module psum_shadow_bank: capture-enable register of NUM_PE x PSUM_W plus an idx-selected read mux (and ReLU when enabled).
//  The FSM, idx counter, address adder and flags live in psum_drain_ctrl.
// TESTING
//  1. Reset, then drainStart with psumIn[k]=k+1, baseAddr=8'h10, outReady=1.
//     -> rstnPsumDrain=0 at t+1 only; 16 words 1..16 at addr 0x10..0x1F on t+2..t+17; done at t+18.
//  2. Same drain, outReady toggling 1,0,0,1...
//     -> outData/outAddr held while stalled; word order and count (16) unchanged; done 1 cycle after the 16th accept.
//  3. baseAddr=8'hFA -> addresses FA..FF then 00..09; no flag.
//  4. drainStart pulsed again at the 5th SEND cycle -> ignored; stream unaffected; overrun=1 persists until rstnSys=0.
//  5. rstnSys=0 asserted mid-SEND (idx=7) -> outputs immediately return to reset values, no done pulse; a subsequent drainStart runs a full clean drain.
//  6. psumIn[0]=16'hFFFE, psumIn[1]=16'h0005: with DRAIN_RELU_EN -> 0x0000, 0x0005; without -> 0xFFFE, 0x0005.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared defaults and drain FSM encoding for the systolic array output path.
package systolic_pkg;

   localparam int unsigned ROWS   = 4;
   localparam int unsigned COLS   = 4;
   localparam int unsigned PSUM_W = 16;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned NUM_PE = ROWS * COLS;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StClear = 2'd1,
      StSend  = 2'd2,
      StDone  = 2'd3
   } drain_state_e;

   // Index width that stays legal for a single-PE array.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/psum_shadow_bank.sv
// Snapshot register of all PE psums plus an index-selected read port.
// DRAIN_RELU_EN: clamp negative read data to zero.
module psum_shadow_bank
   import systolic_pkg::*;
#(
   parameter int unsigned NUM_PE = systolic_pkg::NUM_PE,
   parameter int unsigned PSUM_W = systolic_pkg::PSUM_W,
   parameter int unsigned IDX_W  = idx_width(NUM_PE)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cap_en,
   input  logic [NUM_PE*PSUM_W-1:0] psum_flat,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic [PSUM_W-1:0]        rd_data
);

   logic [PSUM_W-1:0] bank_q [NUM_PE];
   logic [PSUM_W-1:0] word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NUM_PE; k++) begin
            bank_q[k] <= '0;
         end
      end else if (cap_en) begin
         for (int unsigned k = 0; k < NUM_PE; k++) begin
            bank_q[k] <= psum_flat[k*PSUM_W +: PSUM_W];
         end
      end
   end

   always_comb begin
      word = '0;
      if (32'(rd_idx) < NUM_PE) begin
         word = bank_q[rd_idx];
      end
`ifdef DRAIN_RELU_EN
      rd_data = word[PSUM_W-1] ? '0 : word;
`else
      rd_data = word;
`endif
   end

endmodule

// File: rtl/psum_drain_ctrl.sv
// Snapshots the PE psums on drainStart, clears the array, then streams the words out row-major.
// DRAIN_RELU_EN (optional): clamp negative drained psums to zero.
module psum_drain_ctrl
   import systolic_pkg::*;
#(
   parameter int unsigned ROWS   = systolic_pkg::ROWS,
   parameter int unsigned COLS   = systolic_pkg::COLS,
   parameter int unsigned PSUM_W = systolic_pkg::PSUM_W,
   parameter int unsigned ADDR_W = systolic_pkg::ADDR_W
) (
   input  logic                          clk,
   input  logic                          rstnSys,
   input  logic                          drainStart,
   input  logic [ADDR_W-1:0]             baseAddr,
   input  logic [ROWS*COLS*PSUM_W-1:0]   psumIn,
   output logic [ROWS*COLS-1:0]          rstnPsumDrain,
   output logic                          outValid,
   input  logic                          outReady,
   output logic [PSUM_W-1:0]             outData,
   output logic [ADDR_W-1:0]             outAddr,
   output logic                          busy,
   output logic                          done,
   output logic                          overrun
);

   localparam int unsigned NUM_PE = ROWS * COLS;
   localparam int unsigned IDX_W  = idx_width(NUM_PE);

   drain_state_e      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              overrun_q, overrun_d;
   logic              cap_en;
   logic              send;
   logic [PSUM_W-1:0] rd_data;

   always_ff @(posedge clk or negedge rstnSys) begin
      if (!rstnSys) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         base_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         base_q    <= base_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_d    = base_q;
      cap_en    = 1'b0;
      // A start request outside IDLE is dropped but remembered until reset.
      overrun_d = overrun_q | (drainStart && (state_q != StIdle));
      unique case (state_q)
         StIdle: begin
            if (drainStart) begin
               cap_en  = 1'b1;
               base_d  = baseAddr;
               idx_d   = '0;
               state_d = StClear;
            end
         end
         StClear: state_d = StSend;
         StSend: begin
            if (outReady) begin
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(NUM_PE - 1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   psum_shadow_bank #(
      .NUM_PE (NUM_PE),
      .PSUM_W (PSUM_W),
      .IDX_W  (IDX_W)
   ) u_shadow_bank (
      .clk       (clk),
      .rst_n     (rstnSys),
      .cap_en    (cap_en),
      .psum_flat (psumIn),
      .rd_idx    (idx_q),
      .rd_data   (rd_data)
   );

   assign send          = (state_q == StSend);
   assign outValid      = send;
   assign outData       = send ? rd_data : '0;
   assign outAddr       = send ? ADDR_W'(base_q + ADDR_W'(idx_q)) : '0;
   assign busy          = (state_q == StClear) || send;
   assign done          = (state_q == StDone);
   assign rstnPsumDrain = {NUM_PE{state_q != StClear}};
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Scoreboard bench for psum_drain_ctrl: model pushes expected words, monitor pops on accept.
module tb_psum_drain_ctrl;

   localparam int NPE = 16;
   localparam int PW  = 16;
   localparam int AW  = 8;

   logic                clk = 1'b0;
   logic                rstnSys;
   logic                drainStart;
   logic [AW-1:0]       baseAddr;
   logic [NPE*PW-1:0]   psumIn;
   logic [NPE-1:0]      rstnPsumDrain;
   logic                outValid;
   logic                outReady;
   logic [PW-1:0]       outData;
   logic [AW-1:0]       outAddr;
   logic                busy;
   logic                done;
   logic                overrun;

   psum_drain_ctrl #(
      .ROWS   (4),
      .COLS   (4),
      .PSUM_W (PW),
      .ADDR_W (AW)
   ) dut (
      .clk           (clk),
      .rstnSys       (rstnSys),
      .drainStart    (drainStart),
      .baseAddr      (baseAddr),
      .psumIn        (psumIn),
      .rstnPsumDrain (rstnPsumDrain),
      .outValid      (outValid),
      .outReady      (outReady),
      .outData       (outData),
      .outAddr       (outAddr),
      .busy          (busy),
      .done          (done),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] data;
      logic [AW-1:0] addr;
      bit            last;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 0;  // 0: always ready, 1: pattern 1,0,0, 2: random
   int   ready_cyc = 0;
   logic [PW-1:0] psum_arr [NPE];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] model_word(input logic [PW-1:0] v);
`ifdef DRAIN_RELU_EN
      return ($signed(v) < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic load_psums();
      for (int k = 0; k < NPE; k++) psumIn[k*PW +: PW] = psum_arr[k];
   endtask

   task automatic push_expected(input logic [AW-1:0] base);
      exp_t e;
      for (int k = 0; k < NPE; k++) begin
         e.data = model_word(psum_arr[k]);
         e.addr = AW'((int'(base) + k) % 256);
         e.last = (k == NPE - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(outValid), 0);
      chk({tag, "_data"}, 32'(outData), 0);
      chk({tag, "_addr"}, 32'(outAddr), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_clear"}, 32'(rstnPsumDrain), 32'hFFFF);
   endtask

   // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
   task automatic run_drain(input logic [AW-1:0] base, input bit pulse_again);
      int n;
      push_expected(base);
      load_psums();
      baseAddr   = base;
      drainStart = 1'b1;
      @(posedge clk); #1;
      drainStart = 1'b0;
      for (int k = 0; k < NPE; k++) psumIn[k*PW +: PW] = PW'($urandom);
      @(negedge clk);
      chk("clear_low", 32'(rstnPsumDrain), 0);
      chk("clear_busy", 32'(busy), 1);
      chk("clear_valid", 32'(outValid), 0);
      @(negedge clk);
      chk("send_clear_high", 32'(rstnPsumDrain), 32'hFFFF);
      chk("send_valid", 32'(outValid), 1);
      if (pulse_again) begin
         repeat (4) @(posedge clk);
         #1 drainStart = 1'b1;
         @(posedge clk); #1 drainStart = 1'b0;
      end
      n = 0;
      while (n < 500) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      if (n == 500) begin
         errors++; checks++;
         $display("FAIL done_timeout: got no done expected done within 500 cycles");
      end
      chk("queue_empty", 32'(exp_q.size()), 0);
      exp_q.delete();
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 0);
   endtask

   // Ready driver
   always @(posedge clk) begin
      #1;
      ready_cyc++;
      case (ready_mode)
         0:       outReady = 1'b1;
         1:       outReady = ((ready_cyc % 3) == 0);
         default: outReady = 1'($urandom);
      endcase
   end

   // Monitor
   bit            done_exp = 0;
   bit            prev_stall = 0;
   logic [PW-1:0] prev_data;
   logic [AW-1:0] prev_addr;
   always @(negedge clk) begin
      exp_t e;
      if (!rstnSys) begin
         done_exp   = 0;
         prev_stall = 0;
      end else begin
         if (done || done_exp) chk("done_pulse", 32'(done), 32'(done_exp));
         if (prev_stall && outValid) begin
            chk("stall_data", 32'(outData), 32'(prev_data));
            chk("stall_addr", 32'(outAddr), 32'(prev_addr));
         end
         done_exp = 0;
         if (outValid && outReady) begin
            if (exp_q.size() == 0) begin
               errors++; checks++;
               $display("FAIL unexpected_word: got 0x%0h expected no word", outData);
            end else begin
               e = exp_q.pop_front();
               chk("word_data", 32'(outData), 32'(e.data));
               chk("word_addr", 32'(outAddr), 32'(e.addr));
               done_exp = e.last;
            end
         end
         prev_stall = outValid && !outReady;
         prev_data  = outData;
         prev_addr  = outAddr;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish by 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      rstnSys    = 1'b0;
      drainStart = 1'b0;
      baseAddr   = '0;
      psumIn     = '0;
      outReady   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      chk("reset_overrun", 32'(overrun), 0);
      rstnSys = 1'b1;
      @(posedge clk); #1;

      // Basic ascending drain
      for (int k = 0; k < NPE; k++) psum_arr[k] = PW'(k + 1);
      ready_mode = 0;
      run_drain(8'h10, 0);

      // Stalls
      ready_mode = 1;
      run_drain(8'h10, 0);

      // Address wrap plus signed words
      ready_mode = 0;
      for (int k = 0; k < NPE; k++) psum_arr[k] = PW'($urandom);
      psum_arr[0] = 16'hFFFE;
      psum_arr[1] = 16'h0005;
      run_drain(8'hFA, 0);
      chk("no_overrun", 32'(overrun), 0);

      // Second start mid-stream
      for (int k = 0; k < NPE; k++) psum_arr[k] = PW'($urandom);
      run_drain(8'h40, 1);
      chk("overrun_set", 32'(overrun), 1);
      ready_mode = 2;
      run_drain(8'h80, 0);
      chk("overrun_sticky", 32'(overrun), 1);

      // Reset at idx 7
      ready_mode = 0;
      for (int k = 0; k < NPE; k++) psum_arr[k] = PW'($urandom);
      push_expected(8'h20);
      load_psums();
      baseAddr   = 8'h20;
      drainStart = 1'b1;
      @(posedge clk); #1 drainStart = 1'b0;
      repeat (8) @(posedge clk);
      #1 rstnSys = 1'b0;
      #1;
      check_reset_outputs("midreset");
      chk("midreset_overrun", 32'(overrun), 0);
      chk("midreset_consumed", 32'(exp_q.size()), NPE - 7);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rstnSys = 1'b1;
      @(posedge clk); #1;
      run_drain(8'h30, 0);

      // Random drains
      for (int d = 0; d < 4; d++) begin
         ready_mode = 2;
         for (int k = 0; k < NPE; k++) psum_arr[k] = PW'($urandom);
         run_drain(AW'($urandom), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
